ldtu_encoder_pq: RTL and testbench

Parametrised successor of the LiTe-DTU stream encoder. It packs a stream of 13-bit samples into 32-bit words: runs of baseline samples are truncated to `BAS_W` bits, and signal samples are packed in pairs. It also supports a fallback raw-pair mode, orbit header words with an embedded orbit counter, and an output FIFO with a ready/valid handshake and overflow detection. It sits between the sample-selection FIFO and the serialiser.

---
 rtl/ldtu_encoder_pq.sv | 228 ++++++++++++++++++++++
 tb/tb_ldtu_encoder_pq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldtu_encoder_pq.sv
// ldtu_encoder_pq
//   Packs a stream of 13-bit samples into 32-bit words for the serialiser.
//   Runs of baseline samples are truncated to BAS_W bits and packed NBAS to a
//   word. Signal samples are packed in pairs. A raw-pair fallback mode, orbit
//   header words and an output FIFO with overflow detection are included.
//
// Ports
//   CLK          rising-edge clock
//   rst_b        asynchronous active-low reset
//   in_valid     sample qualifier for in_data / in_bas
//   in_data      13-bit sample
//   in_bas       1 = baseline sample, 0 = signal sample
//   orbit        one-cycle orbit marker (independent of in_valid)
//   fallback     level, 1 = raw-pair mode
//   out_data     FIFO head word (32'hF000_0000 when empty)
//   out_valid    FIFO not empty
//   out_ready    consumer accepts the head word
//   fifo_level   FIFO occupancy
//   overflow     sticky flag, set when a cycle's pushes had to be dropped
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both 1. While out_valid=1 and out_ready=0 the head word is held stable,
// and out_valid never drops without a transfer (only reset clears it).
module ldtu_encoder_pq #(
    parameter int          BAS_W  = 6,
    parameter int          DEPTH  = 4,
    parameter logic [12:0] HEADER = 13'b1111000001111,
    parameter logic [12:0] SYNC   = 13'b0101010101010
) (
    input  logic                    CLK,
    input  logic                    rst_b,
    input  logic                    in_valid,
    input  logic [12:0]             in_data,
    input  logic                    in_bas,
    input  logic                    orbit,
    input  logic                    fallback,
    output logic [31:0]             out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow
);

    localparam int NBAS = 30 / BAS_W;
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;

    // Packer state
    logic [3:0]  k_q, k_d;
    logic        p_q, p_d;
    logic        f_q, f_d;
    logic        fb_q;
    logic [29:0] bas_q, bas_d;
    logic [12:0] sig_q, sig_d;
    logic [12:0] fbs_q, fbs_d;
    logic [12:0] orbit_cnt_q, orbit_cnt_d;

    // FIFO state
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    // Candidate pushes of this cycle, in processing order
    logic        fl_v, hd_v, sm_v;
    logic [31:0] fl_w, hd_w, sm_w;
    logic [31:0] part_w;
    logic        flush;

    always_comb begin
        k_d         = k_q;
        p_d         = p_q;
        f_d         = f_q;
        bas_d       = bas_q;
        sig_d       = sig_q;
        fbs_d       = fbs_q;
        orbit_cnt_d = orbit_cnt_q;
        fl_v        = 1'b0;
        fl_w        = '0;
        hd_v        = 1'b0;
        hd_w        = '0;
        sm_v        = 1'b0;
        sm_w        = '0;
        // Unused baseline slots are always zero, so the count field can be ORed in.
        part_w      = {2'b10, bas_q | (30'(k_q) << (30 - BAS_W))};
        flush       = orbit | (fallback != fb_q);

        // Flush the open partial using the state of the old mode.
        if (flush) begin
            if (k_q != 4'd0) begin
                fl_v = 1'b1;
                fl_w = part_w;
            end else if (p_q) begin
                fl_v = 1'b1;
                fl_w = {6'b001011, SYNC, sig_q};
            end else if (f_q) begin
                fl_v = 1'b1;
                fl_w = {4'b1111, 1'b1, ~^fbs_q, 13'd0, fbs_q};
            end
            k_d   = 4'd0;
            p_d   = 1'b0;
            f_d   = 1'b0;
            bas_d = '0;
        end

        if (orbit) begin
            hd_v        = 1'b1;
            hd_w        = {6'b001011, HEADER, orbit_cnt_q};
            orbit_cnt_d = orbit_cnt_q + 13'd1;
        end

        // Sample handling sees the post-flush state and the new mode. Whenever
        // k_d/p_d/f_d are still set here no flush happened, so the _q copies
        // (sig_q, fbs_q, part_w) are the live pending values.
        if (in_valid) begin
            if (fallback) begin
                if (!f_d) begin
                    fbs_d = in_data;
                    f_d   = 1'b1;
                end else begin
                    sm_v = 1'b1;
                    sm_w = {4'b1111, ~^in_data, ~^fbs_q, in_data, fbs_q};
                    f_d  = 1'b0;
                end
            end else if (in_bas) begin
                if (p_d) begin
                    sm_v  = 1'b1;
                    sm_w  = {6'b001011, SYNC, sig_q};
                    p_d   = 1'b0;
                    bas_d = 30'(in_data[BAS_W-1:0]);
                    k_d   = 4'd1;
                end else begin
                    bas_d = bas_d | (30'(in_data[BAS_W-1:0]) << (int'(k_d) * BAS_W));
                    if (int'(k_d) + 1 == NBAS) begin
                        sm_v  = 1'b1;
                        sm_w  = {2'b01, bas_d};
                        k_d   = 4'd0;
                        bas_d = '0;
                    end else begin
                        k_d = k_d + 4'd1;
                    end
                end
            end else begin
                if (k_d != 4'd0) begin
                    sm_v  = 1'b1;
                    sm_w  = part_w;
                    k_d   = 4'd0;
                    bas_d = '0;
                    sig_d = in_data;
                    p_d   = 1'b1;
                end else if (!p_d) begin
                    sig_d = in_data;
                    p_d   = 1'b1;
                end else begin
                    sm_v = 1'b1;
                    sm_w = {6'b001010, in_data, sig_q};
                    p_d  = 1'b0;
                end
            end
        end
    end

    // At most two candidates are valid in one cycle; A is the earlier one.
    logic [31:0]   word_a, word_b;
    logic [LW-1:0] n_push, free_sp, accept;
    logic          drop, pop;

    always_comb begin
        word_a  = fl_v ? fl_w : (hd_v ? hd_w : sm_w);
        word_b  = (fl_v && hd_v) ? hd_w : sm_w;
        n_push  = LW'(fl_v) + LW'(hd_v) + LW'(sm_v);
        // Free space excludes this cycle's pop.
        free_sp = LW'(DEPTH) - cnt_q;
        drop    = (n_push > free_sp);
        accept  = drop ? '0 : n_push;
        pop     = out_valid & out_ready;
        cnt_d   = cnt_q + accept - LW'(pop);
        wp_d    = wp_q + AW'(accept);
        rp_d    = rp_q + AW'(pop);
        ovf_d   = ovf_q | drop;
    end

    always_ff @(posedge CLK) begin
        if (accept != '0) begin
            mem[wp_q] <= word_a;
        end
        if (accept == LW'(2)) begin
            mem[wp_q + AW'(1)] <= word_b;
        end
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            k_q         <= '0;
            p_q         <= 1'b0;
            f_q         <= 1'b0;
            fb_q        <= 1'b0;
            bas_q       <= '0;
            sig_q       <= '0;
            fbs_q       <= '0;
            orbit_cnt_q <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            k_q         <= k_d;
            p_q         <= p_d;
            f_q         <= f_d;
            fb_q        <= fallback;
            bas_q       <= bas_d;
            sig_q       <= sig_d;
            fbs_q       <= fbs_d;
            orbit_cnt_q <= orbit_cnt_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid  = (cnt_q != '0);
    assign out_data   = out_valid ? mem[rp_q] : 32'hF000_0000;
    assign fifo_level = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ldtu_encoder_pq.sv
// Testbench for ldtu_encoder_pq: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_ldtu_encoder_pq;

    localparam int          BAS_W  = 6;
    localparam int          DEPTH  = 4;
    localparam int          NBAS   = 30 / BAS_W;
    localparam logic [12:0] HEADER = 13'b1111000001111;
    localparam logic [12:0] SYNC   = 13'b0101010101010;

    logic        CLK = 1'b0;
    logic        rst_b = 1'b0;
    logic        in_valid = 1'b0;
    logic [12:0] in_data = '0;
    logic        in_bas = 1'b0;
    logic        orbit = 1'b0;
    logic        fallback = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [2:0]  fifo_level;
    logic        overflow;

    // clock / reset block
    always #5 CLK = ~CLK;

    ldtu_encoder_pq #(
        .BAS_W (BAS_W),
        .DEPTH (DEPTH),
        .HEADER(HEADER),
        .SYNC  (SYNC)
    ) dut (
        .CLK       (CLK),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_bas    (in_bas),
        .orbit     (orbit),
        .fallback  (fallback),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_level(fifo_level),
        .overflow  (overflow)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard: expected FIFO contents, head first
    logic [31:0] exp_q[$];

    // reference model state: pending samples kept as plain lists
    logic [12:0] m_bas[$];
    logic [12:0] m_sig[$];
    logic [12:0] m_fbs[$];
    logic        m_fb;
    logic [12:0] m_cnt;
    logic        m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] w_baseline(input logic full);
        logic [31:0] w;
        w = full ? 32'h4000_0000 : (32'h8000_0000 | (32'(m_bas.size()) << (30 - BAS_W)));
        for (int i = 0; i < m_bas.size(); i++) w = w | (32'(m_bas[i]) << (i * BAS_W));
        return w;
    endfunction

    function automatic logic [31:0] w_sig(input logic [12:0] s1, input logic [12:0] s2, input logic single);
        return single ? {6'b001011, SYNC, s1} : {6'b001010, s2, s1};
    endfunction

    function automatic logic [31:0] w_fb(input logic [12:0] s1, input logic [12:0] s2);
        return {4'b1111, ~^s2, ~^s1, s2, s1};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_bas.delete();
        m_sig.delete();
        m_fbs.delete();
        m_fb  = 1'b0;
        m_cnt = '0;
        m_ovf = 1'b0;
    endtask

    // One rising edge of the model, using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] pend[$];
        int          free;
        logic        do_pop;
        if (orbit || (fallback != m_fb)) begin
            if (m_bas.size() > 0)      pend.push_back(w_baseline(1'b0));
            else if (m_sig.size() > 0) pend.push_back(w_sig(m_sig[0], 13'd0, 1'b1));
            else if (m_fbs.size() > 0) pend.push_back(w_fb(m_fbs[0], 13'd0));
            m_bas.delete();
            m_sig.delete();
            m_fbs.delete();
        end
        if (orbit) begin
            pend.push_back({6'b001011, HEADER, m_cnt});
            m_cnt = m_cnt + 13'd1;
        end
        if (in_valid) begin
            if (fallback) begin
                m_fbs.push_back(in_data);
                if (m_fbs.size() == 2) begin
                    pend.push_back(w_fb(m_fbs[0], m_fbs[1]));
                    m_fbs.delete();
                end
            end else if (in_bas) begin
                if (m_sig.size() > 0) begin
                    pend.push_back(w_sig(m_sig[0], 13'd0, 1'b1));
                    m_sig.delete();
                end
                m_bas.push_back(in_data & 13'((1 << BAS_W) - 1));
                if (m_bas.size() == NBAS) begin
                    pend.push_back(w_baseline(1'b1));
                    m_bas.delete();
                end
            end else begin
                if (m_bas.size() > 0) begin
                    pend.push_back(w_baseline(1'b0));
                    m_bas.delete();
                end
                m_sig.push_back(in_data);
                if (m_sig.size() == 2) begin
                    pend.push_back(w_sig(m_sig[0], m_sig[1], 1'b0));
                    m_sig.delete();
                end
            end
        end
        m_fb   = fallback;
        free   = DEPTH - exp_q.size();
        do_pop = (exp_q.size() > 0) && out_ready;
        if (do_pop) void'(exp_q.pop_front());
        if (pend.size() > free) m_ovf = 1'b1;
        else foreach (pend[i]) exp_q.push_back(pend[i]);
    endtask

    task automatic check_outputs();
        logic [31:0] exp_head;
        exp_head = (exp_q.size() > 0) ? exp_q[0] : 32'hF000_0000;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("out_data", out_data, exp_head);
        check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_outputs();
    endtask

    // driver: apply one cycle of inputs (called at a falling edge)
    task automatic drive(input logic iv, input logic [12:0] d, input logic b,
                         input logic orb, input logic fb, input logic rdy);
        in_valid  = iv;
        in_data   = d;
        in_bas    = b;
        orbit     = orb;
        fallback  = fb;
        out_ready = rdy;
        step();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic apply_reset();
        rst_b = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1;
        rst_b = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        apply_reset();

        // five baselines -> one full word
        for (int i = 1; i <= 5; i++) drive(1'b1, 13'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        check("full_word", out_data, 32'h4510_3081);
        check("full_level", 32'(fifo_level), 32'd1);

        // two baselines then a signal -> partial word
        apply_reset();
        drive(1'b1, 13'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 13'h0007, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 13'h1ABC, 1'b0, 1'b0, 1'b0, 1'b0);
        check("partial_word", out_data, 32'h8200_01C3);

        // signal pair, then unpaired signal closed by a baseline
        apply_reset();
        drive(1'b1, 13'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 13'h1FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pair_word", out_data, 32'h2BFF_E001);
        drive(1'b1, 13'h0123, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 13'h0005, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pair_single_level", 32'(fifo_level), 32'd2);
        drive(1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("single_word", out_data, 32'h2D55_4123);

        // orbit with a pending signal: single then header, counter advances
        apply_reset();
        drive(1'b1, 13'h0042, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 13'h0077, 1'b0, 1'b1, 1'b0, 1'b0);
        check("orbit_level", 32'(fifo_level), 32'd2);
        check("orbit_single", out_data, 32'h2D55_4042);
        drive(1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check("orbit2_level", 32'(fifo_level), 32'd4);
        drive(1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("header0", out_data, 32'h2FC1_E000);
        drive(1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("header1", out_data, 32'h2FC1_E001);

        // fallback pair and leftover flush on mode exit
        apply_reset();
        drive(1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("empty_flush_level", 32'(fifo_level), 32'd0);
        drive(1'b1, 13'h0FFF, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 13'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fb_word", out_data, 32'hF400_2FFF);
        drive(1'b1, 13'h0055, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fb_flush_level", 32'(fifo_level), 32'd2);
        drive(1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fb_flush_word", out_data, 32'hFC00_0055);

        // overflow: fill, drop a word, drop again with a simultaneous pop
        apply_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 13'($urandom_range(0, 8191)), 1'b0, 1'b0, 1'b0, 1'b0);
        check("full_level4", 32'(fifo_level), 32'd4);
        drive(1'b1, 13'h0A0A, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 13'h0B0B, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'd4);
        drive(1'b1, 13'h0C0C, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 13'h0D0D, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_pop_level", 32'(fifo_level), 32'd3);
        for (int i = 0; i < 4; i++) drive(1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("drained_level", 32'(fifo_level), 32'd0);

        // mid-word reset discards partial state
        drive(1'b1, 13'h0011, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 13'h0022, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 13'(i + 8), 1'b1, 1'b0, 1'b0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end
            drive(1'($urandom_range(0, 3) != 0),
                  13'($urandom_range(0, 8191)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 63) == 0) ? ~fallback : fallback,
                  1'($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
